// File: rtl/stack_pkg.sv
// ============================================================================
// Module      : stack_pkg
// Description : Shared defaults and FSM state encoding for the stack controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int AW_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_ctrl.sv
// ============================================================================
// Module      : stack_ctrl
// Description : LIFO controller driving an external synchronous-read stackram
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic             err_over,
  output logic             err_under,
  output logic             err_coll,
  output logic [AW-1:0]    ram_a,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_q
);

  localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

  state_t           r_state;
  state_t           w_state_next;
  logic [AW:0]      r_sp;
  logic [AW:0]      w_sp_dec;
  logic [AW-1:0]    r_ram_a;
  logic [WIDTH-1:0] r_ram_d;
  logic             r_ram_we;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_err_over;
  logic             r_err_under;
  logic             r_err_coll;
  logic             w_acc_push;
  logic             w_acc_pop;
  logic             w_set_over;
  logic             w_set_under;
  logic             w_set_coll;
  logic             w_full;
  logic             w_empty;

  assign w_full   = (r_sp == c_depth);
  assign w_empty  = (r_sp == '0);
  assign w_sp_dec = r_sp - 1'b1;

  // Pop has priority over push; requests only count in IDLE
  always_comb begin
    w_state_next = r_state;
    w_acc_push   = 1'b0;
    w_acc_pop    = 1'b0;
    w_set_over   = 1'b0;
    w_set_under  = 1'b0;
    w_set_coll   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pop) begin
          w_set_coll = push;
          if (w_empty) begin
            w_set_under = 1'b1;
          end else begin
            w_acc_pop    = 1'b1;
            w_state_next = RD;
          end
        end else if (push) begin
          if (w_full) begin
            w_set_over = 1'b1;
          end else begin
            w_acc_push   = 1'b1;
            w_state_next = WR;
          end
        end
      end
      WR:      w_state_next = IDLE;
      RD:      w_state_next = CAP;
      CAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sp        <= '0;
      r_ram_a     <= '0;
      r_ram_d     <= '0;
      r_ram_we    <= 1'b0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_err_over  <= 1'b0;
      r_err_under <= 1'b0;
      r_err_coll  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ram_we    <= w_acc_push;
      r_pop_valid <= (r_state == CAP);
      if (w_acc_push) begin
        r_ram_a <= r_sp[AW-1:0];
        r_ram_d <= push_data;
        r_sp    <= r_sp + 1'b1;
      end else if (w_acc_pop) begin
        r_ram_a <= w_sp_dec[AW-1:0];
        r_sp    <= w_sp_dec;
      end
      if (r_state == CAP) begin
        r_pop_data <= ram_q;
      end
      // A fresh error event outranks a simultaneous clear
      r_err_over  <= w_set_over  | (r_err_over  & ~err_clr);
      r_err_under <= w_set_under | (r_err_under & ~err_clr);
      r_err_coll  <= w_set_coll  | (r_err_coll  & ~err_clr);
    end
  end

  // Gating with rst keeps a reset landing in WR from committing the write
  assign ram_we    = r_ram_we & ~rst;
  assign ram_a     = r_ram_a;
  assign ram_d     = r_ram_d;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign busy      = (r_state != IDLE);
  assign full      = w_full;
  assign empty     = w_empty;
  assign err_over  = r_err_over;
  assign err_under = r_err_under;
  assign err_coll  = r_err_coll;

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
// ============================================================================
// Module      : tb_stack_ctrl
// Description : Directed self-checking bench for stack_ctrl with stackram model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_ctrl;

  localparam int WIDTH = 12;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             busy;
  logic             full;
  logic             empty;
  logic             err_over;
  logic             err_under;
  logic             err_coll;
  logic [AW-1:0]    ram_a;
  logic [WIDTH-1:0] ram_d;
  logic             ram_we;
  logic [WIDTH-1:0] ram_q;

  logic [WIDTH-1:0] mem [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // stackram: write on we, registered read of the presented address
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  stack_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .err_clr(err_clr), .pop_data(pop_data), .pop_valid(pop_valid),
    .busy(busy), .full(full), .empty(empty), .err_over(err_over),
    .err_under(err_under), .err_coll(err_coll), .ram_a(ram_a),
    .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, empty, full, pop_valid, ram_we} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got busy/empty/full/pv/we=%b want 01000",
               {busy, empty, full, pop_valid, ram_we});
    end
    checks++;
    if ({pop_data, ram_d, ram_a} !== '0) begin
      errors++;
      $display("FAIL reset_data: got pop_data=%h ram_d=%h ram_a=%0d want 0", pop_data, ram_d, ram_a);
    end
    checks++;
    if ({err_over, err_under, err_coll} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: got %b want 000", {err_over, err_under, err_coll});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      push_data = 12'(i + 1);
      tick();
      push = 1'b0;
      checks++;
      if ({ram_we, busy, ram_a, ram_d} !== {1'b1, 1'b1, 2'(i), 12'(i + 1)}) begin
        errors++;
        $display("FAIL push_%0d: got we=%b busy=%b a=%0d d=%h want we=1 busy=1 a=%0d d=%h",
                 i, ram_we, busy, ram_a, ram_d, i, i + 1);
      end
      tick();
      checks++;
      if ({ram_we, busy, mem[i]} !== {1'b0, 1'b0, 12'(i + 1)}) begin
        errors++;
        $display("FAIL push_done_%0d: got we=%b busy=%b mem=%h want we=0 busy=0 mem=%h",
                 i, ram_we, busy, mem[i], i + 1);
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_after_4: got %b want 1", full);
    end
    push = 1'b1;
    push_data = 12'h005;
    tick();
    push = 1'b0;
    checks++;
    if ({ram_we, busy, err_over, full} !== 4'b0011) begin
      errors++;
      $display("FAIL overflow: got we/busy/err_over/full=%b want 0011",
               {ram_we, busy, err_over, full});
    end
  endtask

  task automatic pop_expect(input logic [WIDTH-1:0] exp, input logic [AW-1:0] exp_a);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if ({busy, pop_valid, ram_we, ram_a} !== {1'b1, 1'b0, 1'b0, exp_a}) begin
      errors++;
      $display("FAIL pop_issue: got busy=%b pv=%b we=%b a=%0d want 1 0 0 a=%0d",
               busy, pop_valid, ram_we, ram_a, exp_a);
    end
    tick();
    checks++;
    if ({busy, pop_valid} !== 2'b10) begin
      errors++;
      $display("FAIL pop_wait: got busy=%b pv=%b want 1 0", busy, pop_valid);
    end
    tick();
    checks++;
    if ({busy, pop_valid, pop_data} !== {1'b0, 1'b1, exp}) begin
      errors++;
      $display("FAIL pop_data: got busy=%b pv=%b data=%h want 0 1 %h", busy, pop_valid, pop_data, exp);
    end
    tick();
    checks++;
    if ({pop_valid, pop_data} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL pop_hold: got pv=%b data=%h want 0 %h", pop_valid, pop_data, exp);
    end
  endtask

  task automatic test_drain();
    pop_expect(12'h004, 2'd3);
    pop_expect(12'h003, 2'd2);
    pop_expect(12'h002, 2'd1);
    pop_expect(12'h001, 2'd0);
    checks++;
    if ({empty, full} !== 2'b10) begin
      errors++;
      $display("FAIL empty_after_drain: got empty/full=%b want 10", {empty, full});
    end
  endtask

  task automatic test_underflow();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if ({err_over, err_under, err_coll} !== 3'b000) begin
      errors++;
      $display("FAIL clr_over: got %b want 000", {err_over, err_under, err_coll});
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if ({err_under, busy, pop_valid, empty} !== 4'b1001) begin
      errors++;
      $display("FAIL underflow: got err_under/busy/pv/empty=%b want 1001",
               {err_under, busy, pop_valid, empty});
    end
    tick();
    tick();
    checks++;
    if (pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow_no_pv: got %b want 0", pop_valid);
    end
    err_clr = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (err_under !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_event: got err_under=%b want 1", err_under);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_under !== 1'b0) begin
      errors++;
      $display("FAIL clr_under: got err_under=%b want 0", err_under);
    end
  endtask

  task automatic do_push(input logic [WIDTH-1:0] val);
    push = 1'b1;
    push_data = val;
    tick();
    push = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    do_push(12'h111);
    do_push(12'hABC);
    push = 1'b1;
    pop = 1'b1;
    push_data = 12'h555;
    tick();
    push = 1'b0;
    pop = 1'b0;
    checks++;
    if ({ram_we, busy, err_coll, ram_a} !== {1'b0, 1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL coll_issue: got we=%b busy=%b coll=%b a=%0d want 0 1 1 1",
               ram_we, busy, err_coll, ram_a);
    end
    tick();
    tick();
    checks++;
    if ({pop_valid, pop_data, mem[2]} !== {1'b1, 12'hABC, 12'h003}) begin
      errors++;
      $display("FAIL coll_pop: got pv=%b data=%h mem2=%h want 1 abc 003", pop_valid, pop_data, mem[2]);
    end
    tick();
    pop_expect(12'h111, 2'd0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL coll_sp: got empty=%b want 1", empty);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_abort();
    do_push(12'h222);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, pop_valid, empty} !== 3'b001) begin
      errors++;
      $display("FAIL rst_in_rd: got busy/pv/empty=%b want 001", {busy, pop_valid, empty});
    end
    tick();
    checks++;
    if (pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_rd_pv: got %b want 0", pop_valid);
    end
    push = 1'b1;
    push_data = 12'h7FF;
    tick();
    push = 1'b0;
    checks++;
    if ({ram_we, ram_a, ram_d} !== {1'b1, 2'd0, 12'h7FF}) begin
      errors++;
      $display("FAIL push_after_rst: got we=%b a=%0d d=%h want 1 0 7ff", ram_we, ram_a, ram_d);
    end
    tick();
    push = 1'b1;
    push_data = 12'h333;
    tick();
    push = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wr_we: got %b want 0", ram_we);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({mem[1], mem[0], empty, busy} !== {12'hABC, 12'h7FF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_in_wr: got mem1=%h mem0=%h empty=%b busy=%b want abc 7ff 1 0",
               mem[1], mem[0], empty, busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_push(12'h010);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    push = 1'b1;
    push_data = 12'h020;
    tick();
    checks++;
    if ({ram_we, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_busy: got we=%b busy=%b want 0 1", ram_we, busy);
    end
    tick();
    checks++;
    if ({pop_valid, pop_data, ram_we, busy, err_coll, err_over} !== {1'b1, 12'h010, 4'b0000}) begin
      errors++;
      $display("FAIL b2b_pop: got pv=%b data=%h we=%b busy=%b coll=%b over=%b want 1 010 0 0 0 0",
               pop_valid, pop_data, ram_we, busy, err_coll, err_over);
    end
    tick();
    push = 1'b0;
    checks++;
    if ({ram_we, ram_a, ram_d} !== {1'b1, 2'd0, 12'h020}) begin
      errors++;
      $display("FAIL b2b_push: got we=%b a=%0d d=%h want 1 0 020", ram_we, ram_a, ram_d);
    end
    tick();
    checks++;
    if ({ram_we, empty} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_once: got we=%b empty=%b want 0 0", ram_we, empty);
    end
    pop_expect(12'h020, 2'd0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_single: got empty=%b want 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_collision();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, stack entry width in bits.
REQ-002 SHALL have parameter AW, default 2, stackram address width; depth = 2**AW = 4.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port push  input  1  push request, sampled only when busy=0.
REQ-006 SHALL have port pop  input  1  pop request, sampled only when busy=0.
REQ-007 SHALL have port push_data  input  WIDTH  value to push, sampled with push.
REQ-008 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-009 SHALL have port pop_data  output  WIDTH  last popped value, held until the next pop completes.
REQ-010 SHALL have port pop_valid  output  1  one-cycle strobe, pop_data updated.
REQ-011 SHALL have port busy  output  1  operation in progress, requests ignored.
REQ-012 SHALL have ports full, empty  output  1 each  stack occupancy flags.
REQ-013 SHALL have ports err_over, err_under, err_coll  output  1 each  sticky overflow, underflow and collision flags.
REQ-014 SHALL have ports ram_a  output  AW, ram_d  output  WIDTH, ram_we  output  1, ram_q  input  WIDTH  connection to stackram (q, a, d, we, clk).

Function
REQ-015 SHALL treat stackram as: write of d to mem[a] on the clk edge where we=1; read data on q valid one edge after a is presented.
REQ-016 SHALL keep stack pointer sp, AW+1 bits, range 0..4; empty = (sp==0), full = (sp==4), both combinational from sp.
REQ-017 SHALL implement FSM states IDLE, WR, RD, CAP.
REQ-018 IDLE, push=1, pop=0, not full: next WR; registered ram_a=sp[AW-1:0], ram_d=push_data, ram_we=1; sp+1.
REQ-019 WR: ram_we=1 for exactly one cycle, busy=1; next IDLE with ram_we=0.
REQ-020 IDLE, pop=1, not empty: next RD; registered ram_a=sp-1; sp-1; busy=1.
REQ-021 RD: busy=1, next CAP; CAP: pop_data <= ram_q, pop_valid=1 for the following cycle, next IDLE.
REQ-022 Pop latency: pop_valid high in the cycle after the 2nd rising edge following the sampling edge; busy low in that cycle, so a new request is accepted there.
REQ-023 Push when full: no write, sp unchanged, err_over set, stays IDLE.
REQ-024 Pop when empty: no read, sp unchanged, err_under set, no pop_valid, stays IDLE.
REQ-025 push and pop together in IDLE: pop executes (subject to REQ-024), push dropped, err_coll set.
REQ-026 Requests with busy=1 SHALL be ignored, with no flag set.
REQ-027 err_clr=1 SHALL clear all error flags; a new error event in the same cycle SHALL win (flag stays set).
REQ-028 ram_we SHALL be 0 in every state except WR.

Reset
REQ-029 rst=1 at an edge: state IDLE, sp=0, ram_we=0, ram_a=0, ram_d=0, pop_data=0, pop_valid=0, busy=0, all error flags 0.
REQ-030 Reset during WR, RD or CAP SHALL abort the operation (no write, no pop_valid); stackram contents are not cleared.

Structure
REQ-031 Shared package stack_pkg SHALL hold WIDTH/AW defaults and the FSM state enumeration.
REQ-032 stack_ctrl SHALL contain no memory; the testbench top instantiates stack_ctrl plus stackram. No sub-module.

Verification
REQ-033 Push 0x001,0x002,0x003,0x004 -> ram writes at a=0..3, full=1 after 4th; 5th push 0x005 -> no ram_we, err_over=1.
REQ-034 From full, four pops -> pop_data 0x004,0x003,0x002,0x001 each with a one-cycle pop_valid 3 edges after request; empty=1 at end.
REQ-035 Pop when empty -> err_under=1, no pop_valid; err_clr pulse -> err_under=0.
REQ-036 push=1, pop=1 with sp=2, top=0xABC -> pop_data=0xABC, sp=1, err_coll=1, no write.
REQ-037 rst asserted in RD state -> no pop_valid, sp=0, busy=0 next cycle; subsequent push 0x7FF writes a=0.
REQ-038 push held high while busy during a pop -> exactly one push accepted after pop_valid cycle.
